// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY edges,
// then completes with a one-cycle ready pulse. Storage is split into byte lanes.

module data_memory_lane #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_idx,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);
    logic [7:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_idx];
endmodule

module data_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_din,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_dout,
    output logic        o_mem_ready,
    output logic        o_mem_err,
    output logic        o_stall
);
    localparam int         NUM_LANES = 4;
    localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_din;
    logic [2:0]            r_funct3;
    logic                  r_rd, r_wr, r_err;
    logic [31:0]           r_dout;

    logic                  w_idle, w_req, w_enter_done;
    logic                  w_rd, w_wr, w_err, w_bad_f3, w_misal;
    logic [ADDR_WIDTH+1:0] w_addr;
    logic [2:0]            w_funct3;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_rword, w_load;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [NUM_LANES-1:0]  w_be;
    logic [31:0]           w_wdata;
    logic                  w_commit;
    logic                  w_unused_addr;

    assign w_idle = (r_state == S_IDLE);
    assign w_req  = i_mem_read | i_mem_write;

    // In IDLE (LATENCY==1 enters DONE straight from here) the live inputs are
    // what gets decoded; afterwards only the latched copies count.
    assign w_rd     = w_idle ? i_mem_read                : r_rd;
    assign w_wr     = w_idle ? i_mem_write               : r_wr;
    assign w_addr   = w_idle ? i_addr[ADDR_WIDTH+1:0]    : r_addr;
    assign w_funct3 = w_idle ? i_funct3                  : r_funct3;
    assign w_idx    = w_addr[ADDR_WIDTH+1:2];

    assign w_unused_addr = &{1'b0, i_addr[31:ADDR_WIDTH+2]};

    assign w_bad_f3 = (w_funct3 == 3'b011) | (w_funct3 == 3'b110) | (w_funct3 == 3'b111);
    assign w_misal  = ((w_funct3[1:0] == 2'b01) & w_addr[0]) |
                      ((w_funct3[1:0] == 2'b10) & (|w_addr[1:0]));
    assign w_err    = w_bad_f3 | w_misal | (w_rd & w_wr);

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_cnt_nxt = LAT_M1;
                    w_next    = (LATENCY == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_done = (w_next == S_DONE) & (r_state != S_DONE);

    always_comb begin
        w_byte = w_rword[7:0];
        case (w_addr[1:0])
            2'd0: w_byte = w_rword[7:0];
            2'd1: w_byte = w_rword[15:8];
            2'd2: w_byte = w_rword[23:16];
            2'd3: w_byte = w_rword[31:24];
            default: w_byte = w_rword[7:0];
        endcase
        w_half = w_addr[1] ? w_rword[31:16] : w_rword[15:0];
        case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_rword;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_din    <= 32'd0;
            r_funct3 <= 3'd0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_err    <= 1'b0;
            r_dout   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_enter_done & w_err;
            if (w_idle && w_req) begin
                r_addr   <= i_addr[ADDR_WIDTH+1:0];
                r_din    <= i_din;
                r_funct3 <= i_funct3;
                r_rd     <= i_mem_read;
                r_wr     <= i_mem_write;
            end
            // Stores leave dout alone; errors force it to zero.
            if (w_enter_done) begin
                if (w_err)     r_dout <= 32'd0;
                else if (w_rd) r_dout <= w_load;
            end
        end
    end

    // Store commits on the edge leaving DONE; a reset in flight drops it
    // because the state register has already fallen back to IDLE.
    assign w_commit = (r_state == S_DONE) & r_wr & ~r_err;

    always_comb begin
        w_be    = '0;
        w_wdata = r_din;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_din[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_din[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = r_din;
            end
            default: begin
                w_be    = '0;
                w_wdata = r_din;
            end
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            data_memory_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
                .i_clk   (i_clk),
                .i_we    (w_commit & w_be[g]),
                .i_idx   (w_idx),
                .i_wdata (w_wdata[g*8 +: 8]),
                .o_rdata (w_rword[g*8 +: 8])
            );
        end
    endgenerate

    assign o_dout      = r_dout;
    assign o_mem_ready = (r_state == S_DONE);
    assign o_mem_err   = r_err;
    assign o_stall     = i_reset & ~o_mem_ready & (~w_idle | w_req);
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=3 main instance plus a
// LATENCY=1 instance, hand-computed expected values.

module tb_data_memory_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rd, wr, l_rd, l_wr;
    logic [31:0] addr, din, l_addr, l_din;
    logic [2:0]  f3, l_f3;
    logic [31:0] dout, l_dout;
    logic        ready, err, stall, l_ready, l_err, l_stall;

    int n_vec = 0;
    int n_bad = 0;

    data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_mem_read(rd), .i_mem_write(wr),
        .i_addr(addr), .i_din(din), .i_funct3(f3),
        .o_dout(dout), .o_mem_ready(ready), .o_mem_err(err), .o_stall(stall)
    );

    data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_l1 (
        .i_clk(clk), .i_reset(rst_n), .i_mem_read(l_rd), .i_mem_write(l_wr),
        .i_addr(l_addr), .i_din(l_din), .i_funct3(l_f3),
        .o_dout(l_dout), .o_mem_ready(l_ready), .o_mem_err(l_err), .o_stall(l_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one transaction starting in the current (IDLE) cycle and returns in
    // the cycle after DONE, checking stall/ready every cycle and dout/err at DONE.
    task automatic xact(input string name, input bit sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input logic [31:0] exp_dout, input logic exp_err);
        int lat;
        lat = sel ? 1 : 3;
        if (sel) begin l_rd = r; l_wr = w; l_addr = a; l_din = d; l_f3 = f; end
        else     begin rd = r;   wr = w;   addr = a;   din = d;   f3 = f;   end
        @(negedge clk);
        chk({name, ".c0_stall"}, 32'(sel ? l_stall : stall), 32'd1);
        chk({name, ".c0_ready"}, 32'(sel ? l_ready : ready), 32'd0);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                if (sel) begin l_rd = 0; l_wr = 0; end
                else     begin rd = 0;   wr = 0;   end
            end
            @(negedge clk);
            if (c < lat) begin
                chk({name, ".wait_stall"}, 32'(stall), 32'd1);
                chk({name, ".wait_ready"}, 32'(ready), 32'd0);
            end else begin
                chk({name, ".done_ready"}, 32'(sel ? l_ready : ready), 32'd1);
                chk({name, ".done_stall"}, 32'(sel ? l_stall : stall), 32'd0);
                chk({name, ".done_err"},   32'(sel ? l_err : err), 32'(exp_err));
                chk({name, ".done_dout"},  sel ? l_dout : dout, exp_dout);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd = 0; wr = 0; addr = 0; din = 0; f3 = 0;
        l_rd = 0; l_wr = 0; l_addr = 0; l_din = 0; l_f3 = 0;
        repeat (2) @(posedge clk);
        #1 rd = 1;
        @(negedge clk);
        chk("rst.dout",  dout, 32'd0);
        chk("rst.ready", 32'(ready), 32'd0);
        chk("rst.err",   32'(err), 32'd0);
        chk("rst.stall_with_req", 32'(stall), 32'd0);
        rd = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle.stall", 32'(stall), 32'd0);

        xact("sw_10",   0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        0);
        xact("lw_10",   0, 1, 0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0);
        xact("sb_11",   0, 0, 1, 32'h11, 32'h5A,       3'b000, 32'hDEADBEEF, 0);
        xact("lw_10b",  0, 1, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD5AEF, 0);
        xact("lb_13",   0, 1, 0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE, 0);
        xact("lbu_13",  0, 1, 0, 32'h13, 32'h0,        3'b100, 32'h000000DE, 0);
        xact("lh_12",   0, 1, 0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 0);
        xact("lhu_12",  0, 1, 0, 32'h12, 32'h0,        3'b101, 32'h0000DEAD, 0);
        xact("lb_11",   0, 1, 0, 32'h11, 32'h0,        3'b000, 32'h0000005A, 0);
        xact("lh_10",   0, 1, 0, 32'h10, 32'h0,        3'b001, 32'h00005AEF, 0);
        xact("lw_wrap", 0, 1, 0, 32'h1010, 32'h0,      3'b010, 32'hDEAD5AEF, 0);
        xact("lw_mis",  0, 1, 0, 32'h12, 32'h0,        3'b010, 32'h0,        1);
        xact("sh_mis",  0, 0, 1, 32'h11, 32'hFFFF,     3'b001, 32'h0,        1);
        xact("lw_rb1",  0, 1, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD5AEF, 0);
        xact("rw_both", 0, 1, 1, 32'h10, 32'h0,        3'b010, 32'h0,        1);
        xact("lw_rb2",  0, 1, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD5AEF, 0);
        xact("bad_f3",  0, 1, 0, 32'h10, 32'h0,        3'b011, 32'h0,        1);

        // Request held continuously: completions at cycles 3, 7, 11.
        rd = 1; addr = 32'h10; f3 = 3'b010;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("b2b.ready_c%0d", c), 32'(ready),
                32'((c == 3) || (c == 7) || (c == 11)));
            chk($sformatf("b2b.stall_c%0d", c), 32'(stall),
                32'(!((c == 3) || (c == 7) || (c == 11))));
            if (c == 11) rd = 0;
            @(posedge clk); #1;
        end
        chk("b2b.dout", dout, 32'hDEAD5AEF);
        @(negedge clk);
        chk("b2b.idle_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;

        xact("sw_20", 0, 0, 1, 32'h20, 32'hCAFEF00D, 3'b010, 32'hDEAD5AEF, 0);

        // Store aborted by reset in cycle 2.
        wr = 1; addr = 32'h20; din = 32'h12345678; f3 = 3'b010;
        @(posedge clk); #1;
        wr = 0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort.dout",  dout, 32'd0);
        chk("abort.ready", 32'(ready), 32'd0);
        chk("abort.err",   32'(err), 32'd0);
        chk("abort.stall", 32'(stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xact("lw_20", 0, 1, 0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 0);

        // LATENCY=1 instance.
        xact("l1_sw",  1, 0, 1, 32'h0, 32'hA5A5A5A5, 3'b010, 32'h0,        0);
        xact("l1_lw",  1, 1, 0, 32'h0, 32'h0,        3'b010, 32'hA5A5A5A5, 0);
        xact("l1_lbu", 1, 1, 0, 32'h1, 32'h0,        3'b100, 32'h000000A5, 0);
        xact("l1_err", 1, 1, 0, 32'h2, 32'h0,        3'b010, 32'h0,        1);
        @(negedge clk);
        chk("l1.idle_ready", 32'(l_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
